// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU opcodes and
// the bit positions of the packed {carry, zero, overflow} flag triple.
package alu_arb_pkg;

    typedef enum logic {IDLE, EXEC} state_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_EQ  = 4'b1111;

    localparam int unsigned FLAG_OVF   = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_CARRY = 2;
    localparam int unsigned NUM_FLAGS  = 3;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant, purely combinational. The pointer selects the
// winner only when both inputs request; the pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    assign gnt_idx   = (req == 2'b11) ? ptr : req[1];
    assign gnt_valid = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for a shared external ALU: grants one of two requesters,
// drives the ALU from registered operands, and parks result/flags in per-requester slots.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*WIDTH-1:0]     req_a,
    input  logic [2*WIDTH-1:0]     req_b,
    input  logic [2*SEL_W-1:0]     req_sel,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [2*WIDTH-1:0]     resp_result,
    output logic [2*NUM_FLAGS-1:0] resp_flags,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_ovf
);

    state_e state_q, state_d;
    logic   ptr_q;
    logic   gidx_q;

    logic [1:0] eligible;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       gnt_valid;

    logic [WIDTH-1:0]     alu_a_q, alu_b_q;
    logic [SEL_W-1:0]     alu_sel_q;
    logic [1:0]           resp_valid_q;
    logic [WIDTH-1:0]     result_q [2];
    logic [NUM_FLAGS-1:0] flags_q  [2];
    logic [NUM_FLAGS-1:0] flags_d;

    // A slot being drained this cycle still counts as occupied: no bypass.
    assign eligible = req_valid & ~resp_valid_q;

    rr_arb2 u_rr_arb2 (
        .req       (eligible),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (gnt_valid) state_d = EXEC;
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE) begin
            req_ready = gnt;
        end
    end

    always_comb begin
        flags_d             = '0;
        flags_d[FLAG_CARRY] = alu_carry;
        flags_d[FLAG_ZERO]  = alu_zero;
        flags_d[FLAG_OVF]   = alu_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            gidx_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            resp_valid_q <= '0;
            result_q[0]  <= '0;
            result_q[1]  <= '0;
            flags_q[0]   <= '0;
            flags_q[1]   <= '0;
        end else begin
            if (state_q == IDLE && gnt_valid) begin
                alu_a_q   <= gnt_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                alu_b_q   <= gnt_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                alu_sel_q <= gnt_idx ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
                gidx_q    <= gnt_idx;
            end
            for (int i = 0; i < 2; i++) begin
                if (resp_ready[i]) resp_valid_q[i] <= 1'b0;
            end
            // The captured slot was empty at grant, so this never races a drain.
            if (state_q == EXEC) begin
                resp_valid_q[gidx_q] <= 1'b1;
                result_q[gidx_q]     <= alu_out;
                flags_q[gidx_q]      <= flags_d;
                ptr_q                <= ~gidx_q;
            end
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = {result_q[1], result_q[0]};
    assign resp_flags  = {flags_q[1], flags_q[0]};
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, directed scenarios and a random
// soak scored against a transaction-level model of grants and response slots.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [2*W-1:0]  req_a, req_b, resp_result;
    logic [2*SW-1:0] req_sel;
    logic [5:0]      resp_flags;
    logic [W-1:0]    alu_a, alu_b, alu_out;
    logic [SW-1:0]   alu_sel;
    logic            alu_carry, alu_zero, alu_ovf;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .SEL_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sel     (req_sel),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_ovf     (alu_ovf)
    );

    // Returns {carry, zero, ovf, result}.
    function automatic logic [W+2:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [SW-1:0] sel);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_EQ:  r = (a == b) ? 32'd1 : 32'd0;
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
        endcase
        return {c, (r == '0), v, r};
    endfunction

    assign {alu_carry, alu_zero, alu_ovf, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

    int n_tests = 0;
    int n_fail  = 0;
    int drained = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, two response slots, favoured requester.
    logic           m_busy;
    int             m_g;
    logic           m_fav;
    logic [1:0]     m_full;
    logic [W+2:0]   q0[$];
    logic [W+2:0]   q1[$];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W+2:0] qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    // Evaluate at the negedge, advance the model across the next posedge, return at posedge+1.
    task automatic tick();
        logic [1:0]   elig, exp_rdy;
        logic [W+2:0] e;
        int           g;
        @(negedge clk);
        elig    = req_valid & ~m_full;
        exp_rdy = 2'b00;
        if (!m_busy && elig != 2'b00) begin
            if (elig == 2'b11) exp_rdy = m_fav ? 2'b10 : 2'b01;
            else               exp_rdy = elig;
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        check_eq("resp_valid", 64'(resp_valid), 64'(m_full));
        for (int i = 0; i < 2; i++) begin
            if (m_full[i]) begin
                if (qsize(i) == 0) begin
                    check_eq("resp_unexpected", 64'd0, 64'd1);
                end else begin
                    e = qfront(i);
                    check_eq("resp_result", 64'(resp_result[i*W +: W]), 64'(e[W-1:0]));
                    check_eq("resp_flags", 64'(resp_flags[i*3 +: 3]), 64'(e[W+2:W]));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (m_full[i] && resp_ready[i]) begin
                m_full[i] = 1'b0;
                if (i == 0 && q0.size() > 0) void'(q0.pop_front());
                if (i == 1 && q1.size() > 0) void'(q1.pop_front());
                drained++;
            end
        end
        if (m_busy) begin
            m_full[m_g] = 1'b1;
            m_fav       = (m_g == 0);
            m_busy      = 1'b0;
        end else if (exp_rdy != 2'b00) begin
            g      = exp_rdy[1] ? 1 : 0;
            m_g    = g;
            m_busy = 1'b1;
            e      = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_sel[g*SW +: SW]);
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~exp_rdy;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        #1;
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_result", 64'(resp_result), 64'd0);
        check_eq("rst_resp_flags", 64'(resp_flags), 64'd0);
        check_eq("rst_alu_ab", 64'({alu_a, alu_b}), 64'd0);
        check_eq("rst_alu_sel", 64'(alu_sel), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        m_busy = 1'b0;
        m_g    = 0;
        m_fav  = 1'b0;
        m_full = 2'b00;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SW-1:0] sel);
        req_a[i*W +: W]     = a;
        req_b[i*W +: W]     = b;
        req_sel[i*SW +: SW] = sel;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_resp(input int i);
        int n = 0;
        while (!resp_valid[i] && n < 20) begin
            tick();
            n++;
        end
        check_eq("resp_timeout", 64'(resp_valid[i]), 64'd1);
    endtask

    task automatic drain(input int i);
        resp_ready[i] = 1'b1;
        tick();
        resp_ready[i] = 1'b0;
    endtask

    function automatic logic [SW-1:0] rand_sel();
        logic [SW-1:0] ops [7];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_EQ};
        if ($urandom_range(7, 0) == 0) return SW'($urandom);
        return ops[$urandom_range(6, 0)];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_sel    = '0;
        do_reset();

        // Single request on r0: 5 - 7.
        set_req(0, 32'd5, 32'd7, OP_SUB);
        #1 check_eq("single_ready", 64'(req_ready), 64'b01);
        tick();
        tick();
        check_eq("single_valid", 64'(resp_valid), 64'b01);
        check_eq("single_result", 64'(resp_result[W-1:0]), 64'hFFFF_FFFE);
        check_eq("single_zero", 64'(resp_flags[FLAG_ZERO]), 64'd0);
        drain(0);

        // Contention from reset: r0 favoured, then r1, then pointer returns to r0.
        do_reset();
        set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND);
        set_req(1, 32'h1, 32'h2, OP_OR);
        #1 check_eq("cont_first", 64'(req_ready), 64'b01);
        wait_resp(0);
        check_eq("cont_r0", 64'(resp_result[W-1:0]), 64'hF000_F000);
        wait_resp(1);
        check_eq("cont_r1", 64'(resp_result[2*W-1:W]), 64'h3);
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;
        set_req(0, 32'h7, 32'h8, OP_ADD);
        set_req(1, 32'h9, 32'h1, OP_SUB);
        #1 check_eq("rr_repeat", 64'(req_ready), 64'b01);
        wait_resp(0);
        wait_resp(1);
        check_eq("rr_r1_result", 64'(resp_result[2*W-1:W]), 64'h8);
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;

        // Backpressure on r0 while r1 keeps being served.
        set_req(0, 32'h10, 32'h20, OP_ADD);
        wait_resp(0);
        set_req(0, 32'h1, 32'h1, OP_AND);
        set_req(1, 32'h3, 32'h4, OP_ADD);
        repeat (6) tick();
        check_eq("bp_held", 64'(resp_result[W-1:0]), 64'h30);
        check_eq("bp_r1_served", 64'(resp_valid[1]), 64'd1);
        drain(1);
        check_eq("bp_no_regrant", 64'(req_valid[0]), 64'd1);
        drain(0);
        wait_resp(0);
        check_eq("bp_after_drain", 64'(resp_result[W-1:0]), 64'h1);
        drain(0);

        // Compare operations on r1.
        set_req(1, 32'h1234, 32'h1234, OP_EQ);
        wait_resp(1);
        check_eq("eq_result", 64'(resp_result[2*W-1:W]), 64'h1);
        check_eq("eq_zero", 64'(resp_flags[3+FLAG_ZERO]), 64'd0);
        drain(1);
        set_req(1, 32'hFFFF_FFFF, 32'h1, OP_SLT);
        wait_resp(1);
        check_eq("slt_result", 64'(resp_result[2*W-1:W]), 64'h1);
        drain(1);
        set_req(1, 32'd9, 32'd9, OP_SUB);
        wait_resp(1);
        check_eq("sub_result", 64'(resp_result[2*W-1:W]), 64'h0);
        check_eq("sub_zero", 64'(resp_flags[3+FLAG_ZERO]), 64'd1);
        drain(1);

        // Reset mid-EXEC with the pointer favouring r1 beforehand.
        set_req(0, 32'h2, 32'h3, OP_ADD);
        wait_resp(0);
        drain(0);
        set_req(1, 32'hAAAA_5555, 32'h1234_5678, OP_OR);
        tick();
        check_eq("pre_rst_alu_a", 64'(alu_a), 64'hAAAA_5555);
        do_reset();
        repeat (4) tick();
        check_eq("rst_no_resp", 64'(resp_valid), 64'd0);
        set_req(0, 32'h4, 32'h4, OP_ADD);
        set_req(1, 32'h5, 32'h5, OP_ADD);
        #1 check_eq("rst_ptr", 64'(req_ready), 64'b01);
        wait_resp(0);
        wait_resp(1);
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;

        // Random soak.
        drained = 0;
        for (int c = 0; c < 60000 && drained < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    a = $urandom;
                    b = ($urandom_range(3, 0) == 0) ? a : 32'($urandom);
                    set_req(i, a, b, rand_sel());
                end
            end
            resp_ready = 2'($urandom);
            tick();
        end
        check_eq("soak_count", 64'(drained >= 10000), 64'd1);
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        repeat (4) tick();
        check_eq("soak_q0_empty", 64'(q0.size()), 64'd0);
        check_eq("soak_q1_empty", 64'(q1.size()), 64'd0);
        check_eq("soak_idle", 64'(resp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
